// File: rtl/speechrec_pkg.sv
// Shared definitions for the speech-recognition capture path.
//   state_e  : capture FSM state encoding (2 bits)
//   sample_t : one 8-bit audio sample
//   DEF_DEPTH / DEF_AW : default frame buffer depth and address width
package speechrec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_e;

    typedef logic [7:0] sample_t;

    localparam int DEF_DEPTH = 2000;
    localparam int DEF_AW    = 11;

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer plus history flop for one asynchronous level.
// Ports:
//   clk, reset (async active-low)
//   d      : asynchronous input level
//   level  : synchronized level (2nd flop)
//   any_e  : single-cycle pulse on either edge of level
//   rise   : single-cycle pulse on a 0->1 edge
//   fall   : single-cycle pulse on a 1->0 edge
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic any_e,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign any_e = s2_q ^ hist_q;
    assign rise  = s2_q & ~hist_q;
    assign fall  = ~s2_q & hist_q;

endmodule

// File: rtl/audio_store.sv
// Captures SPI-received audio bytes into a frame buffer, one frame per
// chip-select window, and presents the frame through a ready/consume
// handshake and a registered random-access read port.
// Ports:
//   clk, reset (async active-low)
//   rx_data, rx_toggle : byte and per-byte toggle from the SPI receiver
//   ss                 : SPI chip select, active-low, asynchronous
//   frame_ready, frame_len, consume : frame handshake to the comparator
//   rd_en, rd_addr, rd_data         : 1-cycle-latency read port
//   busy               : capture in progress
//   drop_cnt           : saturating count of bytes dropped while occupied
// Build option: define AUDIO_STORE_DROP_CNT_EN to enable the drop counter;
// otherwise drop_cnt reads as 8'h00.
module audio_store
    import speechrec_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  sample_t       rx_data,
    input  logic          rx_toggle,
    input  logic          ss,
    output logic          frame_ready,
    output logic [AW-1:0] frame_len,
    input  logic          consume,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    logic byte_ev, rx_level, rx_rise, rx_fall;
    logic ss_level, ss_any, ss_rise, ss_fall;

    sync_edge u_rx_sync (
        .clk(clk), .reset(reset), .d(rx_toggle),
        .level(rx_level), .any_e(byte_ev), .rise(rx_rise), .fall(rx_fall)
    );

    sync_edge u_ss_sync (
        .clk(clk), .reset(reset), .d(ss),
        .level(ss_level), .any_e(ss_any), .rise(ss_rise), .fall(ss_fall)
    );

    // Only the edge flavours needed here are consumed.
    logic unused_sync;
    assign unused_sync = &{1'b0, rx_level, rx_rise, rx_fall, ss_level, ss_any};

    state_e        state_q;
    logic [AW-1:0] wr_ptr_q, len_q, wr_inc;
    logic          ready_q, busy_q, wr_en;

    assign wr_inc = wr_ptr_q + AW'(1);
    assign wr_en  = (state_q == CAPTURE) && byte_ev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q  <= CAPTURE;
                        wr_ptr_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (byte_ev) wr_ptr_q <= wr_inc;
                    if (byte_ev && (wr_ptr_q == AW'(DEPTH - 1))) begin
                        // Buffer full: close the frame even though ss is still low.
                        state_q <= READY;
                        len_q   <= AW'(DEPTH);
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (ss_rise) begin
                        // A byte landing with the ss edge is part of the frame.
                        if (byte_ev || (wr_ptr_q != '0)) begin
                            state_q <= READY;
                            len_q   <= byte_ev ? wr_inc : wr_ptr_q;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                        busy_q <= 1'b0;
                    end
                end
                READY: begin
                    if (consume) begin
                        state_q  <= IDLE;
                        wr_ptr_q <= '0;
                        len_q    <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_ready = ready_q;
    assign frame_len   = len_q;
    assign busy        = busy_q;

`ifdef AUDIO_STORE_DROP_CNT_EN
    logic [7:0] drop_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= 8'h00;
        end else if ((state_q == READY) && byte_ev && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'h01;
        end
    end
    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

    // Sample RAM: no reset so it maps onto block memory.
    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= rx_data;
    end

    // Registered read; same-cycle read/write to one address sees old data.
    sample_t rd_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= (rd_addr < AW'(DEPTH)) ? mem[rd_addr] : 8'h00;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: tb/tb_audio_store.sv
module tb_audio_store;

    localparam int DEPTH = 8;
    localparam int AW    = 4;
`ifdef AUDIO_STORE_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_toggle;
    logic          ss;
    logic          frame_ready;
    logic [AW-1:0] frame_len;
    logic          consume;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic [7:0]    drop_cnt;

    int nvec = 0;
    int nerr = 0;
    int drops = 0;
    logic [7:0] sb[$];

    audio_store #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_toggle(rx_toggle),
        .ss(ss), .frame_ready(frame_ready), .frame_len(frame_len),
        .consume(consume), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_toggle = ~rx_toggle;
        cycles(4);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a;
        sb.push_back(exp);
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rd_data, sb.pop_front());
    endtask

    task automatic wait_ready(input string tag, input logic [AW-1:0] exp_len);
        int n = 0;
        while (!frame_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, frame_ready, 1);
        chk({tag, "_len"}, frame_len, exp_len);
    endtask

    task automatic do_consume();
        @(negedge clk);
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
    endtask

    initial begin
        logic [7:0] ovf [10];
        reset = 1'b0; rx_data = 8'h00; rx_toggle = 1'b0; ss = 1'b1;
        consume = 1'b0; rd_en = 1'b0; rd_addr = '0;
        cycles(3);
        // Reset state
        chk("rst_ready", frame_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_rd", rd_data, 0);
        reset = 1'b1;
        cycles(5);

        // Full-frame capture of five bytes
        ss = 1'b0;
        cycles(4);
        chk("cap_busy", busy, 1);
        for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11));
        @(negedge clk); ss = 1'b1;
        wait_ready("full", 5);
        chk("full_busy", busy, 0);
        for (int i = 0; i < 5; i++) do_read("full_rd", AW'(i), 8'((i + 1) * 8'h11));
        cycles(2);
        chk("rd_hold", rd_data, 8'h55);
        do_read("rd_oob9", AW'(9), 8'h00);
        do_read("rd_oob8", AW'(8), 8'h00);

        // READY ignores a new window; its bytes are drops
        @(negedge clk); ss = 1'b0;
        cycles(4);
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
        @(negedge clk); ss = 1'b1;
        cycles(4);
        drops = 3;
        chk("hs_ready", frame_ready, 1);
        chk("hs_len", frame_len, 5);
        chk("hs_busy", busy, 0);
        chk("hs_drop", drop_cnt, DROP_EN ? drops : 0);
        do_read("hs_rd0", AW'(0), 8'h11);
        do_consume();
        chk("cons_ready", frame_ready, 0);
        chk("cons_len", frame_len, 0);
        cycles(3);
        ss = 1'b0;
        cycles(4);
        send_byte(8'hA1);
        send_byte(8'hA2);
        @(negedge clk); ss = 1'b1;
        wait_ready("win2", 2);
        do_read("win2_rd0", AW'(0), 8'hA1);
        do_read("win2_rd1", AW'(1), 8'hA2);
        do_consume();

        // Empty window never presents a frame
        cycles(3);
        ss = 1'b0;
        cycles(6);
        ss = 1'b1;
        cycles(6);
        chk("empty_ready", frame_ready, 0);
        chk("empty_busy", busy, 0);
        chk("empty_len", frame_len, 0);

        // Overflow: DEPTH+2 bytes in one window
        ss = 1'b0;
        cycles(4);
        for (int i = 0; i < 10; i++) ovf[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < DEPTH; i++) send_byte(ovf[i]);
        chk("ovf_ready", frame_ready, 1);
        chk("ovf_len", frame_len, DEPTH);
        chk("ovf_busy", busy, 0);
        send_byte(ovf[8]);
        send_byte(ovf[9]);
        @(negedge clk); ss = 1'b1;
        cycles(4);
        drops += 2;
        chk("ovf_drop", drop_cnt, DROP_EN ? drops : 0);
        chk("ovf_len2", frame_len, DEPTH);
        for (int i = 0; i < DEPTH; i++) do_read("ovf_rd", AW'(i), ovf[i]);
        do_consume();

        // Last byte and ss rise synchronized in the same cycle
        cycles(3);
        ss = 1'b0;
        cycles(4);
        send_byte(8'h5A);
        send_byte(8'h6B);
        @(negedge clk);
        rx_data = 8'h7C;
        rx_toggle = ~rx_toggle;
        ss = 1'b1;
        wait_ready("simul", 3);
        do_read("simul_rd2", AW'(2), 8'h7C);
        do_read("simul_rd0", AW'(0), 8'h5A);
        do_consume();

        // Reset mid-capture drops the partial frame
        cycles(3);
        ss = 1'b0;
        cycles(4);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        @(negedge clk);
        reset = 1'b0;
        ss = 1'b1;
        cycles(2);
        chk("mr_ready", frame_ready, 0);
        chk("mr_busy", busy, 0);
        chk("mr_len", frame_len, 0);
        chk("mr_drop", drop_cnt, 0);
        chk("mr_rd", rd_data, 0);
        reset = 1'b1;
        cycles(5);
        chk("mr_idle_busy", busy, 0);
        ss = 1'b0;
        cycles(4);
        send_byte(8'h91);
        send_byte(8'h92);
        @(negedge clk); ss = 1'b1;
        wait_ready("mr_win", 2);
        do_read("mr_rd1", AW'(1), 8'h92);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
